// File: rtl/pp_accum_if.sv
// Handshake bundle between the Booth PP generator, the accumulator
// and the normalise/round stage.
interface pp_accum_if #(
   parameter int LENGTH = 32
);
   localparam int W = 2 * LENGTH + 2;

   logic         acc_clr;
   logic         pp_valid;
   logic         pp_ready;
   logic [W-1:0] pp_a;
   logic [W-1:0] pp_b;
   logic         pp_cin;
   logic         pp_last;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_data;
   logic         res_ovf;
   logic         res_err;

   modport master (
      output acc_clr, pp_valid, pp_a, pp_b, pp_cin, pp_last, res_ready,
      input  pp_ready, res_valid, res_data, res_ovf, res_err
   );

   modport slave (
      input  acc_clr, pp_valid, pp_a, pp_b, pp_cin, pp_last, res_ready,
      output pp_ready, res_valid, res_data, res_ovf, res_err
   );
endinterface

// File: rtl/pp_accum_ctrl.sv
// Iterative Booth partial-product accumulator: one shared three-operand
// adder folds two PPs plus a correction bit into a running sum per beat.
module full_adder #(
   parameter  int LENGTH = 32,
   localparam int W      = 2 * LENGTH + 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);
   logic [W+1:0] sum;

   assign sum = {2'b00, a} + {2'b00, b} + {2'b00, c}
              + {{(W+1){1'b0}}, ci};
   assign s   = sum[W-1:0];
   // Any spill beyond W bits counts as carry-out
   assign co  = |sum[W+1:W];
endmodule

module pp_accum_ctrl #(
   parameter int LENGTH = 32
) (
   input logic       sys_clk,
   input logic       sys_rst,
   pp_accum_if.slave bus
);
   localparam int W         = 2 * LENGTH + 2;
   localparam int MAX_BEATS = (LENGTH / 2 + 2) / 2;
   localparam int CW        = $clog2(MAX_BEATS + 1);

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   acc;
   logic [W-1:0]   add_a;
   logic [W-1:0]   sum;
   logic [CW-1:0]  beat_cnt;
   logic [CW-1:0]  cnt_nxt;
   logic           ovf;
   logic           ovf_nxt;
   logic           co;
   logic           accept;
   logic           hit;
   logic           done;
   logic [W-1:0]   res_data_q;
   logic           res_ovf_q;
   logic           res_err_q;

   assign bus.pp_ready  = (state != OUT) & ~bus.acc_clr;
   assign bus.res_valid = (state == OUT);
   assign bus.res_data  = res_data_q;
   assign bus.res_ovf   = res_ovf_q;
   assign bus.res_err   = res_err_q;

   assign accept = bus.pp_valid & bus.pp_ready;
   assign add_a  = (state == IDLE) ? '0 : acc;

   full_adder #(.LENGTH(LENGTH)) u_add (
      .a  (add_a),
      .b  (bus.pp_a),
      .c  (bus.pp_b),
      .ci (bus.pp_cin),
      .s  (sum),
      .co (co)
   );

   always_comb begin
      cnt_nxt   = (state == IDLE) ? CW'(1) : beat_cnt + CW'(1);
      ovf_nxt   = ((state == IDLE) ? 1'b0 : ovf) | co;
      hit       = (cnt_nxt == CW'(MAX_BEATS));
      done      = accept & (bus.pp_last | hit);
      state_nxt = state;
      unique case (state)
         IDLE, ACC: begin
            if (done)
               state_nxt = OUT;
            else if (accept)
               state_nxt = ACC;
         end
         OUT: begin
            if (bus.res_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (bus.acc_clr)
         state_nxt = IDLE;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         acc        <= '0;
         beat_cnt   <= '0;
         ovf        <= 1'b0;
         res_data_q <= '0;
         res_ovf_q  <= 1'b0;
         res_err_q  <= 1'b0;
      end else if (bus.acc_clr) begin
         acc      <= '0;
         beat_cnt <= '0;
         ovf      <= 1'b0;
      end else if (accept) begin
         acc      <= sum;
         beat_cnt <= cnt_nxt;
         ovf      <= ovf_nxt;
         if (done) begin
            res_data_q <= sum;
            res_ovf_q  <= ovf_nxt;
            res_err_q  <= ~bus.pp_last & hit;
         end
      end else if (state == OUT && bus.res_ready) begin
         acc      <= '0;
         beat_cnt <= '0;
         ovf      <= 1'b0;
      end
   end
endmodule
